// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the pipeline sequencer FSM state.
package cpu_types_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} pctl_state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage read of a register that the EX-stage load has not produced yet.
module load_use_detect (
  input  logic       memren_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  output logic       lu
);
  assign lu = memren_ex & (rt_ex != 5'd0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: stage enables/flushes, dmem wait/halt FSM and saturating stall/flush counters.
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemren_mem,
  input  logic             dmemwen_mem,
  input  logic             memren_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             jump_id,
  input  logic             branch_taken_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  pctl_state_t state, next_state;
  logic memreq, mem_stall, advance, lu, run, any_flush;
  load_use_detect u_lu (
    .memren_ex(memren_ex),
    .rt_ex(rt_ex),
    .rs_id(rs_id),
    .rt_id(rt_id),
    .lu(lu)
  );
  assign memreq    = dmemren_mem | dmemwen_mem;
  assign mem_stall = memreq & ~dhit;
  assign advance   = ihit & ~mem_stall;
  assign run       = state != HALTED;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= RUN;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      RUN:     next_state = halt_wb ? HALTED : (mem_stall ? DWAIT : RUN);
      DWAIT:   next_state = dhit ? RUN : DWAIT;
      default: next_state = HALTED;
    endcase
  end
  // A taken branch overrides a load-use stall so the PC can take the redirect.
  always_comb begin
    memwb_en    = run & ~mem_stall;
    exmem_en    = run & advance;
    idex_en     = run & advance & ~lu;
    ifid_en     = run & advance & (~lu | branch_taken_mem);
    pc_en       = ifid_en;
    flush_exmem = run & ((~advance & memreq & dhit) | (advance & branch_taken_mem));
    flush_idex  = run & advance & (lu | branch_taken_mem);
    flush_ifid  = run & advance & (branch_taken_mem | (jump_id & ~lu));
    halted      = state == HALTED;
    any_flush   = flush_ifid | flush_idex | flush_exmem;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (run & ~advance & (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (any_flush & (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
endmodule
